vga_cpu_bridge: RTL
===================

// Module: vga_cpu_bridge
// PURPOSE
//  - Upstream stage of the mini-VGA toplevel. Takes JML-8 CPU register writes and turns them
//    into video-RAM writes that the VGA scan-out consumes.
//  - Holds a VRAM address pointer with auto-increment. Buffers write data in a FIFO.
//  - Drains the FIFO into the VRAM write port with a req/ack handshake. The toplevel acks only
//    when the pixel fetcher is idle.
// PARAMETERS
//  - ADDR_W  13  VRAM address width, 1..16.
//  - DEPTH   8   FIFO entries. Power of two, 2..16.
// PORTS
//  - clk        in   1       system clock; single clock domain.
//  - rst_n      in   1       synchronous, active-low reset.
//  - cpu_cs     in   1       chip select.
//  - cpu_we     in   1       write strobe; qualifies with cpu_cs; one-cycle pulse per access.
//  - cpu_re     in   1       read strobe; qualifies with cpu_cs.
//  - cpu_addr   in   2       register select: 0 ADDR_LO, 1 ADDR_HI, 2 DATA, 3 STATUS.
//  - cpu_wdata  in   8       write data.
//  - cpu_rdata  out  8       registered read data.
//  - vram_req   out  1       FIFO head valid.
//  - vram_ack   in   1       VRAM accepted the head entry this cycle.
//  - vram_addr  out  ADDR_W  head entry address.
//  - vram_data  out  8       head entry data.
//  - irq        out  1       only present when VGA_BRIDGE_IRQ_EN is defined.
// BEHAVIOUR
//  - Reset (rst_n low at a posedge):
//    - pointer=0, FIFO empty, overflow=0, drain_done=0.
//    - vram_req=0, vram_addr=0, vram_data=0, cpu_rdata=0, irq=0.
//    - Entries in flight are discarded. vram_req is low from the first edge after reset.
//  - ADDR_LO write sets pointer[7:0]. ADDR_HI write sets pointer[ADDR_W-1:8]; unused bits are
//    ignored. Both take effect at the next edge.
//  - DATA write pushes {pointer, cpu_wdata}, then pointer <= pointer+1 mod 2^ADDR_W
//    (0x1FFF -> 0x0000 at default width).
//  - Push when full is dropped. overflow is set (sticky) and the pointer does not increment.
//  - Push on a full FIFO in the same cycle as a pop (vram_req & vram_ack) is accepted;
//    count stays DEPTH.
//  - Push on an empty FIFO: vram_req high on the next cycle. Minimum latency is 1 clk.
//  - vram_req = !empty. vram_addr/vram_data are the head entry and stay stable while req is
//    high and ack is low.
//  - Pop occurs on a cycle where vram_req & vram_ack. The next entry is presented the
//    following cycle; back-to-back acks drain one entry per clk.
//  - vram_ack while vram_req is low is ignored.
//  - FIFO ordering is strict; there is no reordering or merging.
//  - STATUS read layout:
//    - bit0 full, bit1 empty, bit2 overflow, bit3 drain_done.
//    - bits7:4 count; saturates at 15 (DEPTH=16 full reads 15, full bit set).
//  - STATUS write: writing 1 to bit2 clears overflow and 1 to bit3 clears drain_done. A set
//    event in the same cycle wins over the clear.
//  - drain_done is set when a pop takes count 1 -> 0 with no push in the same cycle.
//  - Reads: cpu_rdata is updated 1 clk after cpu_cs&cpu_re and holds until the next read.
//    DATA/ADDR reads return ADDR_LO=pointer[7:0], ADDR_HI=pointer[15:8] zero-extended,
//    DATA=0x00.
//  - cpu_we and cpu_re in the same cycle: the write is performed and the read returns the
//    pre-write value.
// CONFIGURATION
//  - VGA_BRIDGE_IRQ_EN defined:
//    - irq port exists; registered, irq = overflow | drain_done.
//    - irq deasserts 1 clk after the clearing STATUS write.
//  - VGA_BRIDGE_IRQ_EN undefined:
//    - no irq port and drain_done logic is removed; STATUS bit3 reads 0.
//    - all other behaviour is identical.
// TESTING
//  - Reset: hold rst_n=0 mid-drain with 5 entries queued.
//    -> next cycle vram_req=0, STATUS=0x02, pointer=0.
//  - Write ADDR_LO=0x34, ADDR_HI=0x12, then DATA 0xAA,0xBB with ack held low.
//    -> count=2, head {0x1234,0xAA}, stable.
//    -> ack 2 clks -> {0x1235,0xBB}, then req=0.
//  - Wrap: pointer=0x1FFF, DATA 0x55.
//    -> entry addr 0x1FFF; ADDR_LO/HI read 0x00/0x00.
//  - Overflow: 9 DATA writes with ack=0 at DEPTH=8.
//    -> STATUS=0x85 (count 8, full, overflow); 9th byte absent; pointer advanced by 8.
//  - Full + simultaneous ack and DATA write.
//    -> count stays 8, no overflow, new entry at tail.
//  - IRQ_EN: push 1 then ack.
//    -> drain_done=1, irq=1; write STATUS 0x08 -> irq=0 next clk. Without macro STATUS bit3=0.

Source files
------------

// File: rtl/vga_cpu_bridge.sv
// CPU register port to VRAM write queue: address pointer with auto-increment feeding a req/ack FIFO.
// Optional feature: define VGA_BRIDGE_IRQ_EN to add drain_done tracking and the irq output.
module vga_cpu_bridge #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [1:0]        cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              vram_req,
  input  logic              vram_ack,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_data
`ifdef VGA_BRIDGE_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [7:0]        mem_data [DEPTH];

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [PW-1:0]     wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [4:0]        count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [15:0]       ptr_ext;
  logic [3:0]        count_sat;
  logic [7:0]        status;
  logic              drain_bit;
  logic              wr_en, rd_en, stat_wr, empty, full, pop, push_req, push;

  assign wr_en     = cpu_cs & cpu_we;
  assign rd_en     = cpu_cs & cpu_re;
  assign stat_wr   = wr_en && (cpu_addr == 2'd3);
  assign push_req  = wr_en && (cpu_addr == 2'd2);
  assign empty     = (count_q == 5'd0);
  assign full      = (count_q == 5'(DEPTH));
  assign pop       = !empty && vram_ack;
  // A pop in the same cycle frees the slot, so a push on a full FIFO is still accepted.
  assign push      = push_req && (!full || pop);
  assign ptr_ext   = 16'(ptr_q);
  assign count_sat = (count_q > 5'd15) ? 4'hF : count_q[3:0];
  assign status    = {count_sat, drain_bit, overflow_q, empty, full};

  always_comb begin
    ptr_d = ptr_q;
    if (wr_en) begin
      case (cpu_addr)
        2'd0:    ptr_d = ADDR_W'({ptr_ext[15:8], cpu_wdata});
        2'd1:    ptr_d = ADDR_W'({cpu_wdata, ptr_ext[7:0]});
        default: ;
      endcase
    end
    if (push) ptr_d = ptr_q + ADDR_W'(1);
  end

  always_comb begin
    wr_idx_d = push ? wr_idx_q + PW'(1) : wr_idx_q;
    rd_idx_d = pop ? rd_idx_q + PW'(1) : rd_idx_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: ;
    endcase
    // Set wins over a same-cycle clear.
    overflow_d = (push_req && !push) || (overflow_q && !(stat_wr && cpu_wdata[2]));
  end

  // Read data reflects pre-write state, so a simultaneous write cannot leak into it.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (cpu_addr)
        2'd0:    rdata_d = ptr_ext[7:0];
        2'd1:    rdata_d = ptr_ext[15:8];
        2'd2:    rdata_d = 8'h00;
        default: rdata_d = status;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_idx_q] <= ptr_q;
      mem_data[wr_idx_q] <= cpu_wdata;
    end
  end

  assign cpu_rdata = rdata_q;
  assign vram_req  = !empty;
  assign vram_addr = empty ? '0 : mem_addr[rd_idx_q];
  assign vram_data = empty ? '0 : mem_data[rd_idx_q];

`ifdef VGA_BRIDGE_IRQ_EN
  logic drain_q, drain_d, irq_q;

  always_comb begin
    drain_d = (pop && (count_q == 5'd1) && !push) || (drain_q && !(stat_wr && cpu_wdata[3]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      drain_q <= drain_d;
      irq_q   <= overflow_d | drain_d;
    end
  end

  assign drain_bit = drain_q;
  assign irq       = irq_q;
`else
  assign drain_bit = 1'b0;
`endif

endmodule
